entropy_src_hw_if_arb: RTL and testbench

//  Round-robin arbiter that shares the single entropy_src hardware entropy interface
//  (es_req/es_ack/es_bits/es_fips) between NumReq downstream consumers, e.g. multiple

---
 rtl/entropy_src_hw_if_arb.sv | 118 +++++++++++
 tb/tb_entropy_src_hw_if_arb.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/entropy_src_hw_if_arb.sv
// Round-robin arbiter sharing one entropy_src hardware interface between NumReq consumers.
// One transaction in flight; each seed goes back only to the requester that won it.
module entropy_src_hw_if_arb #(
    parameter int NumReq    = 2,
    parameter int DataWidth = 384
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       enable_i,
    input  logic [NumReq-1:0]          req_i,
    output logic [NumReq-1:0]          ack_o,
    output logic [DataWidth-1:0]       bits_o,
    output logic                       fips_o,
    output logic                       up_req_o,
    input  logic                       up_ack_i,
    input  logic [DataWidth-1:0]       up_bits_i,
    input  logic                       up_fips_i,
    output logic [$clog2(NumReq)-1:0]  grant_idx_o,
    output logic                       busy_o,
    output logic                       err_o
);

    localparam int IdxW = $clog2(NumReq);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DLVR = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [IdxW-1:0]       rr_ptr_q;
    logic [IdxW-1:0]       grant_q;
    logic [IdxW-1:0]       winner;
    logic [IdxW:0]         cand;
    logic                  found;
    logic [DataWidth-1:0]  cap_bits_q;
    logic                  cap_fips_q;
    logic                  err_q;
    logic                  grant_now;

    // Search rr_ptr, rr_ptr+1, ... wrapping at NumReq, which need not be a power of 2.
    always_comb begin
        winner = rr_ptr_q;
        found  = 1'b0;
        cand   = '0;
        for (int i = 0; i < NumReq; i++) begin
            cand = {1'b0, rr_ptr_q} + (IdxW+1)'(i);
            if (cand >= (IdxW+1)'(NumReq)) cand = cand - (IdxW+1)'(NumReq);
            if (!found && req_i[cand[IdxW-1:0]]) begin
                winner = cand[IdxW-1:0];
                found  = 1'b1;
            end
        end
    end

    assign grant_now = (state_q == IDLE) && enable_i && (|req_i);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant_now) state_d = WAIT;
            WAIT:    if (up_ack_i) state_d = req_i[grant_q] ? DLVR : IDLE;
            DLVR:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        up_req_o = (state_q == WAIT);
        busy_o   = (state_q != IDLE);
        ack_o    = '0;
        bits_o   = '0;
        fips_o   = 1'b0;
        if (state_q == DLVR) begin
            ack_o[grant_q] = 1'b1;
            bits_o         = cap_bits_q;
            fips_o         = cap_fips_q;
        end
    end

    // Capture registers only ever hold a seed on its way to a still-requesting winner.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_ptr_q   <= '0;
            grant_q    <= '0;
            cap_bits_q <= '0;
            cap_fips_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            if (grant_now) grant_q <= winner;
            if (state_q == WAIT && up_ack_i) begin
                if (req_i[grant_q]) begin
                    cap_bits_q <= up_bits_i;
                    cap_fips_q <= up_fips_i;
                end else begin
                    cap_bits_q <= '0;
                    cap_fips_q <= 1'b0;
                end
            end
            if (state_q == DLVR) begin
                rr_ptr_q   <= (grant_q == IdxW'(NumReq-1)) ? '0 : grant_q + 1'b1;
                cap_bits_q <= '0;
                cap_fips_q <= 1'b0;
            end
            if (up_ack_i && state_q != WAIT) err_q <= 1'b1;
        end
    end

    assign grant_idx_o = grant_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_entropy_src_hw_if_arb.sv
// Directed bench for entropy_src_hw_if_arb: stimulus pushes expected acks, a monitor pops and checks.
module tb_entropy_src_hw_if_arb;

    localparam int NumReq    = 2;
    localparam int DataWidth = 384;

    typedef struct {
        logic [NumReq-1:0]    mask;
        logic [DataWidth-1:0] bits;
        logic                 fips;
    } exp_t;

    logic                  clk_i = 1'b0;
    logic                  rst_i = 1'b1;
    logic                  enable_i = 1'b0;
    logic [NumReq-1:0]     req_i = '0;
    logic [NumReq-1:0]     ack_o;
    logic [DataWidth-1:0]  bits_o;
    logic                  fips_o;
    logic                  up_req_o;
    logic                  up_ack_i = 1'b0;
    logic [DataWidth-1:0]  up_bits_i = '0;
    logic                  up_fips_i = 1'b0;
    logic [0:0]            grant_idx_o;
    logic                  busy_o;
    logic                  err_o;

    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];

    entropy_src_hw_if_arb #(.NumReq(NumReq), .DataWidth(DataWidth)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .enable_i(enable_i), .req_i(req_i),
        .ack_o(ack_o), .bits_o(bits_o), .fips_o(fips_o), .up_req_o(up_req_o),
        .up_ack_i(up_ack_i), .up_bits_i(up_bits_i), .up_fips_i(up_fips_i),
        .grant_idx_o(grant_idx_o), .busy_o(busy_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every ack must match the head of the scoreboard; idle cycles carry zero data.
    always @(negedge clk_i) begin
        if (!rst_i) begin
            checks++;
            if (ack_o != '0) begin
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_ack: got ack_o=%b with empty scoreboard", ack_o);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (ack_o !== e.mask || bits_o !== e.bits || fips_o !== e.fips) begin
                        failures++;
                        $display("FAIL ack_data: got ack=%b fips=%b bits=%0h expected ack=%b fips=%b bits=%0h",
                                 ack_o, fips_o, bits_o[63:0], e.mask, e.fips, e.bits[63:0]);
                    end
                end
            end else if (bits_o !== '0 || fips_o !== 1'b0) begin
                failures++;
                $display("FAIL idle_data: got fips=%b bits=%0h expected zero", fips_o, bits_o[63:0]);
            end
        end
    end

    task automatic do_reset();
        rst_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
        tick();
    endtask

    task automatic wait_up_req(input string name);
        for (int i = 0; i < 50; i++) begin
            if (up_req_o) break;
            tick();
        end
        chk(name, 64'(up_req_o), 64'd1);
    endtask

    // Upstream model: wait for es_req, hold dly cycles, then pulse es_ack with a seed.
    // On return the DUT is in its delivery cycle (when mask != 0).
    task automatic up_txn(input string name, input logic [NumReq-1:0] mask,
                          input logic [DataWidth-1:0] b, input logic f, input int dly);
        exp_t e;
        wait_up_req(name);
        repeat (dly) tick();
        if (mask != '0) begin
            e.mask = mask;
            e.bits = b;
            e.fips = f;
            sb.push_back(e);
        end
        up_ack_i  = 1'b1;
        up_bits_i = b;
        up_fips_i = f;
        tick();
        up_ack_i  = 1'b0;
        up_bits_i = '0;
        up_fips_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DataWidth-1:0] b;
        rst_i = 1'b1;
        #1;
        chk("reset_up_req", 64'(up_req_o), 0);
        chk("reset_busy",   64'(busy_o), 0);
        chk("reset_ack",    64'(ack_o), 0);
        chk("reset_err",    64'(err_o), 0);
        chk("reset_grant",  64'(grant_idx_o), 0);
        do_reset();
        enable_i = 1'b1;

        // 1: single requester, ack 5 cycles into WAIT
        req_i = 2'b01;
        up_txn("t1_up_req", 2'b01, {48{8'hA5}}, 1'b1, 5);
        req_i = 2'b00;
        tick();
        chk("t1_up_req_low", 64'(up_req_o), 0);
        chk("t1_busy_low",   64'(busy_o), 0);

        // 2: continuous contention, grants must alternate 0,1,0,1
        do_reset();
        req_i = 2'b11;
        for (int n = 0; n < 4; n++) begin
            b = {12{32'hC0DE_0000 + 32'(n)}};
            up_txn("t2_up_req", (n % 2 == 0) ? 2'b01 : 2'b10, b, n[0], 1);
            chk("t2_grant_idx", 64'(grant_idx_o), 64'(n % 2));
            chk("t2_up_req_dlvr", 64'(up_req_o), 0);
        end
        req_i = 2'b00;
        tick();
        tick();

        // 3: requester drops during WAIT; seed discarded, pointer stays at 0
        do_reset();
        req_i = 2'b01;
        wait_up_req("t3_up_req");
        req_i = 2'b00;
        up_txn("t3_drop", 2'b00, {48{8'h3C}}, 1'b1, 2);
        chk("t3_busy_after_drop", 64'(busy_o), 0);
        req_i = 2'b11;
        up_txn("t3_regrant", 2'b01, {48{8'h5A}}, 1'b0, 1);
        chk("t3_grant_idx", 64'(grant_idx_o), 0);
        req_i = 2'b00;
        tick();

        // 4: enable low blocks grants; falling enable in WAIT still completes
        do_reset();
        enable_i = 1'b0;
        req_i    = 2'b01;
        for (int i = 0; i < 6; i++) tick();
        chk("t4_blocked_up_req", 64'(up_req_o), 0);
        chk("t4_blocked_busy",   64'(busy_o), 0);
        enable_i = 1'b1;
        wait_up_req("t4_up_req");
        enable_i = 1'b0;
        up_txn("t4_complete", 2'b01, {48{8'h96}}, 1'b1, 3);
        req_i = 2'b00;
        enable_i = 1'b1;
        tick();

        // 5: stray upstream ack in IDLE sets sticky error
        do_reset();
        up_ack_i  = 1'b1;
        up_bits_i = {48{8'hFF}};
        tick();
        up_ack_i  = 1'b0;
        up_bits_i = '0;
        chk("t5_err_set", 64'(err_o), 1);
        for (int i = 0; i < 4; i++) tick();
        chk("t5_err_sticky", 64'(err_o), 1);
        chk("t5_busy", 64'(busy_o), 0);
        do_reset();
        chk("t5_err_cleared", 64'(err_o), 0);

        // 6: async reset mid-WAIT clears everything, including rr_ptr
        req_i = 2'b01;
        up_txn("t6_first", 2'b01, {48{8'h11}}, 1'b0, 1);
        req_i = 2'b00;
        tick();
        req_i = 2'b01;
        wait_up_req("t6_up_req");
        @(negedge clk_i);
        #1;
        rst_i = 1'b1;
        #1;
        chk("t6_rst_up_req", 64'(up_req_o), 0);
        chk("t6_rst_busy",   64'(busy_o), 0);
        chk("t6_rst_ack",    64'(ack_o), 0);
        chk("t6_rst_err",    64'(err_o), 0);
        chk("t6_rst_grant",  64'(grant_idx_o), 0);
        tick();
        rst_i = 1'b0;
        req_i = 2'b11;
        up_txn("t6_after_rst", 2'b01, {48{8'h22}}, 1'b1, 1);
        chk("t6_grant_idx", 64'(grant_idx_o), 0);
        req_i = 2'b00;
        tick();
        tick();

        chk("sb_empty", 64'(sb.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
